// File: rtl/shared_modn_counter_arb_if.sv
// Bus bundle for the shared mod-N counter arbiter: request/modulus/enable
// from the requesters, grant/count/status back from the counter.
interface shared_modn_counter_arb_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] mod0;
  logic [WIDTH-1:0] mod1;
  logic             en;
  logic [1:0]       gnt;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [1:0]       done;
  logic             err;

  modport master (
    output req, mod0, mod1, en,
    input  gnt, busy, q, done, err
  );

  modport slave (
    input  req, mod0, mod1, en,
    output gnt, busy, q, done, err
  );
endinterface

// File: rtl/shared_modn_counter_arb.sv
// One mod-N counter shared by two requesters under round-robin arbitration;
// each grant runs exactly M enabled ticks, then the FSM drops back to IDLE.
//
//   state  | meaning
//   IDLE   | no run; arbitrate pending requests, reject modulus 1
//   RUN    | counting for the latched winner until terminal count or abort
module shared_modn_counter_arb #(
  parameter int WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  shared_modn_counter_arb_if.slave bus
);

  localparam logic [WIDTH-1:0] L_ZERO = '0;
  localparam logic [WIDTH-1:0] L_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_win;
  logic             r_rr;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_mlat;
  logic [1:0]       r_done;
  logic             r_err;

  logic             w_sel_win;
  logic [WIDTH-1:0] w_sel_mod;
  logic             w_sel_bad;
  logic             w_any_req;
  logic [WIDTH-1:0] w_last;
  logic             w_abort;
  logic             w_term;
  logic [1:0]       w_gnt;
  logic             w_busy;

  // M_lat of 0 means 2^WIDTH; the wrapping subtraction makes w_last all ones.
  always_comb begin
    w_any_req = (bus.req != 2'b00);
    w_sel_win = r_rr;
    if (bus.req == 2'b01)      w_sel_win = 1'b0;
    else if (bus.req == 2'b10) w_sel_win = 1'b1;
    w_sel_mod = w_sel_win ? bus.mod1 : bus.mod0;
    w_sel_bad = (w_sel_mod == L_ONE);
    w_last    = r_mlat - L_ONE;
    w_abort   = !bus.req[r_win];
    w_term    = bus.en && (r_q == w_last);
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req && !w_sel_bad) w_state_nxt = S_RUN;
      S_RUN:   if (w_abort || w_term)       w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win  <= 1'b0;
      r_rr   <= 1'b0;
      r_q    <= L_ZERO;
      r_mlat <= L_ZERO;
      r_done <= 2'b00;
      r_err  <= 1'b0;
    end else begin
      r_done <= 2'b00;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_q <= L_ZERO;
          if (w_any_req) begin
            r_mlat <= w_sel_mod;
            if (w_sel_bad) begin
              r_err <= 1'b1;
              r_rr  <= ~w_sel_win;
            end else begin
              r_win <= w_sel_win;
            end
          end
        end
        S_RUN: begin
          // Abort outranks a coincident terminal count.
          if (w_abort) begin
            r_q  <= L_ZERO;
            r_rr <= ~r_win;
          end else if (w_term) begin
            r_q    <= L_ZERO;
            r_done <= r_win ? 2'b10 : 2'b01;
            r_rr   <= ~r_win;
          end else if (bus.en) begin
            r_q <= r_q + L_ONE;
          end
        end
        default: r_q <= L_ZERO;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state == S_RUN);
    w_gnt  = 2'b00;
    if (w_busy) w_gnt = r_win ? 2'b10 : 2'b01;
  end

  assign bus.gnt  = w_gnt;
  assign bus.busy = w_busy;
  assign bus.q    = r_q;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_shared_modn_counter_arb.sv
// Bench for shared_modn_counter_arb: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a count-to-M model.
module tb_shared_modn_counter_arb;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shared_modn_counter_arb_if #(.WIDTH(WIDTH)) bus ();
  shared_modn_counter_arb #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: a run is "busy with winner w, having counted k of M ticks".
  int m_run = 0, m_win = 0, m_cnt = 0, m_rr = 0, m_M = 0;
  logic [1:0] e_gnt = 0, e_done = 0;
  logic       e_err = 0, e_busy = 0;
  logic [3:0] e_q = 0;

  function automatic void model_step(input logic r, input logic [1:0] rq,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic e);
    int w;
    int mv;
    e_done = 2'b00;
    e_err  = 1'b0;
    if (!r) begin
      m_run = 0; m_cnt = 0; m_rr = 0; m_M = 0;
    end else if (m_run == 0) begin
      if (rq != 2'b00) begin
        if (rq == 2'b01)      w = 0;
        else if (rq == 2'b10) w = 1;
        else                  w = m_rr;
        mv  = (w == 1) ? int'(b) : int'(a);
        m_M = (mv == 0) ? (1 << WIDTH) : mv;
        if (m_M == 1) begin
          e_err = 1'b1;
          m_rr  = 1 - w;
        end else begin
          m_run = 1; m_win = w; m_cnt = 0;
        end
      end
    end else begin
      if (!rq[m_win]) begin
        m_run = 0; m_cnt = 0; m_rr = 1 - m_win;
      end else if (e) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == m_M) begin
          e_done = (m_win == 1) ? 2'b10 : 2'b01;
          m_run = 0; m_cnt = 0; m_rr = 1 - m_win;
        end
      end
    end
    e_busy = (m_run != 0);
    e_gnt  = (m_run == 0) ? 2'b00 : ((m_win == 1) ? 2'b10 : 2'b01);
    e_q    = 4'(m_cnt);
  endfunction

  task automatic expect_out(input string nm, input logic [1:0] g, input logic [3:0] qv,
                            input logic [1:0] d, input logic er, input logic bz);
    n_cmp++;
    if (bus.gnt !== g || bus.q !== qv || bus.done !== d || bus.err !== er || bus.busy !== bz) begin
      n_mis++;
      $display("FAIL %s: got gnt=%b q=%0d done=%b err=%b busy=%b, want gnt=%b q=%0d done=%b err=%b busy=%b",
               nm, bus.gnt, bus.q, bus.done, bus.err, bus.busy, g, qv, d, er, bz);
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] rq, input logic [3:0] a,
                       input logic [3:0] b, input logic e);
    rst = r; bus.req = rq; bus.mod0 = a; bus.mod1 = b; bus.en = e;
    @(posedge clk);
    model_step(r, rq, a, b, e);
    #1;
    n_cmp++;
    if ((bus.done != 2'b00 && bus.err) || !$onehot0(bus.gnt)) begin
      n_mis++;
      $display("FAIL invariant: got gnt=%b done=%b err=%b, want onehot0 gnt and not done&err",
               bus.gnt, bus.done, bus.err);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] mod0;
    logic [3:0] mod1;
    logic       en;
    logic [1:0] gnt;
    logic [3:0] q;
    logic [1:0] done;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [1:0] rq, input logic [3:0] a,
                              input logic [3:0] b, input logic e, input logic [1:0] g,
                              input logic [3:0] qv, input logic [1:0] d, input logic er,
                              input logic bz);
    vec_t v;
    v.rst = r; v.req = rq; v.mod0 = a; v.mod1 = b; v.en = e;
    v.gnt = g; v.q = qv; v.done = d; v.err = er; v.busy = bz;
    tbl.push_back(v);
  endfunction

  initial begin
    bus.req = 2'b00; bus.mod0 = '0; bus.mod1 = '0; bus.en = 1'b0;

    // Single request, modulus 5; mod0 changes mid-run and must be ignored.
    add(0, 2'b00, 0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
    add(1, 2'b01, 5, 0, 1,  2'b01, 0, 2'b00, 0, 1);
    add(1, 2'b01, 5, 0, 1,  2'b01, 1, 2'b00, 0, 1);
    add(1, 2'b01, 2, 0, 1,  2'b01, 2, 2'b00, 0, 1);
    add(1, 2'b01, 2, 0, 1,  2'b01, 3, 2'b00, 0, 1);
    add(1, 2'b01, 2, 0, 1,  2'b01, 4, 2'b00, 0, 1);
    add(1, 2'b01, 2, 0, 1,  2'b00, 0, 2'b01, 0, 0);
    add(1, 2'b00, 2, 0, 1,  2'b00, 0, 2'b00, 0, 0);
    // Rejected modulus, then contention where the error hands over to requester 1.
    add(0, 2'b00, 0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
    add(1, 2'b01, 1, 0, 0,  2'b00, 0, 2'b00, 1, 0);
    add(1, 2'b00, 1, 0, 0,  2'b00, 0, 2'b00, 0, 0);
    add(0, 2'b00, 0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
    add(1, 2'b11, 1, 6, 1,  2'b00, 0, 2'b00, 1, 0);
    add(1, 2'b11, 1, 6, 1,  2'b10, 0, 2'b00, 0, 1);
    add(1, 2'b11, 1, 6, 1,  2'b10, 1, 2'b00, 0, 1);
    add(1, 2'b10, 1, 6, 1,  2'b10, 2, 2'b00, 0, 1);
    add(1, 2'b00, 1, 6, 1,  2'b00, 0, 2'b00, 0, 0);
    // Abort at q=2 coinciding with terminal count of M=3: no done.
    add(0, 2'b00, 0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
    add(1, 2'b01, 3, 0, 1,  2'b01, 0, 2'b00, 0, 1);
    add(1, 2'b01, 3, 0, 1,  2'b01, 1, 2'b00, 0, 1);
    add(1, 2'b01, 3, 0, 1,  2'b01, 2, 2'b00, 0, 1);
    add(1, 2'b00, 3, 0, 1,  2'b00, 0, 2'b00, 0, 0);
    add(1, 2'b00, 3, 0, 0,  2'b00, 0, 2'b00, 0, 0);
    // Reset mid-run at q=2; nothing resumes afterwards.
    add(1, 2'b01, 5, 0, 1,  2'b01, 0, 2'b00, 0, 1);
    add(1, 2'b01, 5, 0, 1,  2'b01, 1, 2'b00, 0, 1);
    add(1, 2'b01, 5, 0, 1,  2'b01, 2, 2'b00, 0, 1);
    add(0, 2'b01, 5, 0, 1,  2'b00, 0, 2'b00, 0, 0);
    add(1, 2'b00, 5, 0, 1,  2'b00, 0, 2'b00, 0, 0);
    add(1, 2'b00, 5, 0, 1,  2'b00, 0, 2'b00, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].mod0, tbl[i].mod1, tbl[i].en);
      expect_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].q, tbl[i].done, tbl[i].err, tbl[i].busy);
    end

    // Contention from reset: requester 0 first (M=3), one IDLE cycle, then requester 1 (M=4).
    apply(0, 2'b00, 0, 0, 0);
    apply(1, 2'b11, 3, 4, 1);
    expect_out("cont_gnt0", 2'b01, 0, 2'b00, 0, 1);
    for (int i = 1; i < 3; i++) begin
      apply(1, 2'b11, 3, 4, 1);
      expect_out("cont_q0", 2'b01, 4'(i), 2'b00, 0, 1);
    end
    apply(1, 2'b11, 3, 4, 1);
    expect_out("cont_done0", 2'b00, 0, 2'b01, 0, 0);
    apply(1, 2'b11, 3, 4, 1);
    expect_out("cont_gnt1", 2'b10, 0, 2'b00, 0, 1);
    for (int i = 1; i < 4; i++) begin
      apply(1, 2'b11, 3, 4, 1);
      expect_out("cont_q1", 2'b10, 4'(i), 2'b00, 0, 1);
    end
    apply(1, 2'b11, 3, 4, 1);
    expect_out("cont_done1", 2'b00, 0, 2'b10, 0, 0);

    // Gapped enable, M=4: only en=1 edges advance.
    apply(0, 2'b00, 0, 0, 0);
    apply(1, 2'b01, 4, 0, 1);
    expect_out("gap_gnt", 2'b01, 0, 2'b00, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      apply(1, 2'b01, 4, 0, 0);
      expect_out("gap_hold", 2'b01, 4'(i - 1), 2'b00, 0, 1);
      apply(1, 2'b01, 4, 0, 1);
      if (i < 4) expect_out("gap_step", 2'b01, 4'(i), 2'b00, 0, 1);
      else       expect_out("gap_done", 2'b00, 0, 2'b01, 0, 0);
    end

    // Full range: modulus 0 means 16 ticks; no done at q=0 mid-run.
    apply(0, 2'b00, 0, 0, 0);
    apply(1, 2'b10, 7, 0, 1);
    expect_out("full_gnt", 2'b10, 0, 2'b00, 0, 1);
    for (int i = 1; i < 16; i++) begin
      apply(1, 2'b10, 7, 0, 1);
      expect_out("full_q", 2'b10, 4'(i), 2'b00, 0, 1);
    end
    apply(1, 2'b10, 7, 0, 1);
    expect_out("full_done", 2'b00, 0, 2'b10, 0, 0);
    apply(1, 2'b00, 7, 0, 1);

    // Random traffic against the model.
    begin
      logic [1:0] rq;
      logic [3:0] a, b;
      logic r, e;
      rq = 2'b00;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 15) == 0) rq = 2'($urandom_range(0, 3));
        a = ($urandom_range(0, 5) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
        b = ($urandom_range(0, 5) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
        e = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 199) != 0);
        apply(r, rq, a, b, e);
        expect_out("rand", e_gnt, e_q, e_done, e_err, e_busy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
